heartbeat_gen: RTL and testbench

Periodic keep-alive generator for the transmitting side of a link whose far end is supervised by a cascaded-counter timeout monitor. It issues a sequence-numbered kick through a valid/ready handshake often enough that the remote timeout never expires. The kick interval restarts whenever other link traffic is sent, since any traffic already clears the remote timeout. If a kick is held off by backpressure for a full interval, the block raises a sticky lateness flag.

---
 rtl/heartbeat_gen.sv | 97 +++++++++
 tb/tb_heartbeat_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_gen.sv
// Keep-alive kick generator: offers a sequence-numbered kick every P_eff cycles,
// restarts the interval on other link traffic, and flags kicks held off for a full interval.
module heartbeat_gen #(
  parameter int CNT_W = 16,
  parameter int SEQ_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_activity,
  output logic             o_kick_valid,
  input  logic             i_kick_ready,
  output logic [SEQ_W-1:0] o_kick_seq,
  output logic             o_late,
  input  logic             i_clear_status
);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, PEND = 2'd2} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] p_m1;
  logic             late_set;

  // P_eff - 1, with a zero period treated as one
  assign p_m1     = (i_period == '0) ? '0 : i_period - ONE;
  assign late_set = (state == PEND) && !i_kick_ready && (wcnt >= p_m1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wcnt         <= '0;
      o_kick_valid <= 1'b0;
      o_kick_seq   <= '0;
      o_late       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable) begin
            state <= COUNT;
            cnt   <= '0;
          end
        end
        COUNT: begin
          if (!i_enable) begin
            state <= IDLE;
          end else if (i_activity) begin
            cnt <= ONE;
            if (p_m1 <= ONE) begin
              state        <= PEND;
              wcnt         <= '0;
              o_kick_valid <= 1'b1;
            end
          end else if (cnt >= p_m1) begin
            // >= so a shrunk period fires at once instead of wrapping
            state        <= PEND;
            wcnt         <= '0;
            o_kick_valid <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PEND: begin
          if (i_kick_ready) begin
            o_kick_seq <= o_kick_seq + SEQ_ONE;
            if (!i_enable) begin
              state        <= IDLE;
              o_kick_valid <= 1'b0;
            end else if (p_m1 == '0) begin
              wcnt <= '0;
            end else begin
              state        <= COUNT;
              cnt          <= ONE;
              o_kick_valid <= 1'b0;
            end
          end else if (wcnt != '1) begin
            wcnt <= wcnt + ONE;
          end
        end
        default: begin
          state        <= IDLE;
          o_kick_valid <= 1'b0;
        end
      endcase

      if (late_set)            o_late <= 1'b1;
      else if (i_clear_status) o_late <= 1'b0;
    end
  end

endmodule

// File: tb/tb_heartbeat_gen.sv
// Bench for heartbeat_gen: timestamp-based reference model checked every cycle,
// directed scenarios with fixed expected cycles, then randomized traffic.
module tb_heartbeat_gen;
  localparam int CNT_W = 16;
  localparam int SEQ_W = 8;
  localparam int HN    = 512;

  logic             i_clk = 1'b0;
  logic             i_rst, i_enable, i_activity, i_kick_ready, i_clear_status;
  logic [CNT_W-1:0] i_period;
  logic             o_kick_valid, o_late;
  logic [SEQ_W-1:0] o_kick_seq;

  heartbeat_gen #(.CNT_W(CNT_W), .SEQ_W(SEQ_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_period(i_period),
    .i_activity(i_activity), .o_kick_valid(o_kick_valid), .i_kick_ready(i_kick_ready),
    .o_kick_seq(o_kick_seq), .o_late(o_late), .i_clear_status(i_clear_status)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0, cyc = 0;
  // model: mode 0 idle, 1 counting, 2 offering; times are absolute cycle numbers
  int m_mode = 0, anchor = 0, pstart = 0, m_seq = 0;
  bit m_late = 1'b0;
  bit vh[HN]; bit lh[HN]; int sh[HN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // advance model to the next cycle from the inputs of cycle cyc
  task automatic model_step();
    int p, waited;
    bit setl;
    p = (i_period == 0) ? 1 : int'(i_period);
    setl = 1'b0;
    if (i_rst) begin
      m_mode = 0; m_seq = 0; m_late = 1'b0;
    end else begin
      case (m_mode)
        0: if (i_enable) begin m_mode = 1; anchor = cyc + 1; end
        1: begin
          if (!i_enable) m_mode = 0;
          else if (i_activity) begin
            anchor = cyc;                      // one cycle already elapsed next cycle
            if (p <= 2) begin m_mode = 2; pstart = cyc + 1; end
          end else if (cyc - anchor >= p - 1) begin
            m_mode = 2; pstart = cyc + 1;
          end
        end
        default: begin
          if (i_kick_ready) begin
            m_seq = (m_seq + 1) % (1 << SEQ_W);
            if (!i_enable) m_mode = 0;
            else if (p == 1) pstart = cyc + 1;
            else begin m_mode = 1; anchor = cyc; end
          end else begin
            waited = cyc - pstart;
            if (waited > 65535) waited = 65535;
            if (waited >= p - 1) setl = 1'b1;
          end
        end
      endcase
      if (setl) m_late = 1'b1;
      else if (i_clear_status) m_late = 1'b0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge i_clk);
    #1;
    cyc++;
    chk("valid", o_kick_valid, (m_mode == 2));
    chk("seq", o_kick_seq, m_seq);
    chk("late", o_late, m_late);
    if (cyc < HN) begin
      vh[cyc] = o_kick_valid; lh[cyc] = o_late; sh[cyc] = int'(o_kick_seq);
    end
  endtask

  // reset, then the next driven cycle is cycle 0
  task automatic start(input int p);
    i_rst = 1'b1; i_enable = 1'b0; i_activity = 1'b0; i_kick_ready = 1'b0;
    i_clear_status = 1'b0; i_period = CNT_W'(p);
    step();
    i_rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < HN; k++) begin vh[k] = 1'b0; lh[k] = 1'b0; sh[k] = 0; end
  endtask

  initial begin
    int n;
    start(4);
    chk("rst_valid", o_kick_valid, 0);
    chk("rst_seq", o_kick_seq, 0);
    chk("rst_late", o_late, 0);

    // free run
    start(4); i_enable = 1'b1; i_kick_ready = 1'b1;
    repeat (14) step();
    chk("free_v4", vh[4], 0); chk("free_v5", vh[5], 1); chk("free_v6", vh[6], 0);
    chk("free_v9", vh[9], 1); chk("free_v13", vh[13], 1);
    chk("free_s5", sh[5], 0); chk("free_s9", sh[9], 1); chk("free_s13", sh[13], 2);
    chk("free_late", lh[13], 0);

    // backpressure, late, clear
    start(4); i_enable = 1'b1;
    while (cyc < 22) begin
      i_kick_ready = (cyc >= 12);
      i_clear_status = (cyc == 20);
      step();
    end
    chk("bp_v5", vh[5], 1); chk("bp_v11", vh[11], 1);
    chk("bp_l8", lh[8], 0); chk("bp_l9", lh[9], 1);
    chk("bp_s13", sh[13], 1); chk("bp_v13", vh[13], 0); chk("bp_v16", vh[16], 1);
    chk("bp_l20", lh[20], 1); chk("bp_l21", lh[21], 0);

    // set and clear in the same cycle
    start(4); i_enable = 1'b1;
    while (cyc < 11) begin i_clear_status = (cyc == 8); step(); end
    chk("setclr_l9", lh[9], 1);

    // activity restarts interval
    start(4); i_enable = 1'b1; i_kick_ready = 1'b1;
    while (cyc < 9) begin i_activity = (cyc == 3); step(); end
    chk("act_v5", vh[5], 0); chk("act_v7", vh[7], 1);
    start(4); i_enable = 1'b1; i_kick_ready = 1'b1; n = 0;
    while (cyc < 40) begin i_activity = (cyc % 3 == 1); step(); n += int'(o_kick_valid); end
    chk("act_none", n, 0);
    i_activity = 1'b0;

    // period 0: continuous valid, seq wrap
    start(0); i_enable = 1'b1; i_kick_ready = 1'b1; n = 0;
    while (cyc < 300) begin step(); if (cyc >= 2) n += int'(o_kick_valid); end
    chk("p0_v1", vh[1], 0); chk("p0_v2", vh[2], 1); chk("p0_cont", n, 299);
    chk("p0_s257", sh[257], 255); chk("p0_s258", sh[258], 0);

    // shrink period mid-count
    start(100); i_enable = 1'b1;
    while (cyc < 54) begin if (cyc == 51) i_period = 2; step(); end
    chk("shrink_v51", vh[51], 0); chk("shrink_v52", vh[52], 1);

    // disable while offering, then while counting
    start(3); i_enable = 1'b1;
    while (cyc < 14) begin
      if (cyc == 5) i_enable = 1'b0;
      i_kick_ready = (cyc == 8);
      step();
    end
    chk("dis_v4", vh[4], 1); chk("dis_v8", vh[8], 1); chk("dis_v9", vh[9], 0);
    chk("dis_v13", vh[13], 0);
    start(4); i_enable = 1'b1; n = 0;
    while (cyc < 12) begin if (cyc == 2) i_enable = 1'b0; step(); n += int'(o_kick_valid); end
    chk("dis_cnt", n, 0);

    // reset mid-offer with seq=7 and late=1
    start(1); i_enable = 1'b1;
    while (cyc < 12) begin
      i_kick_ready = (cyc < 9);
      i_rst = (cyc == 10);
      step();
    end
    i_rst = 1'b0;
    chk("rst_s10", sh[10], 7); chk("rst_l10", lh[10], 1); chk("rst_v10", vh[10], 1);
    chk("rst_v11", vh[11], 0); chk("rst_s11", sh[11], 0); chk("rst_l11", lh[11], 0);

    // randomized traffic against the model
    start(3);
    repeat (3000) begin
      i_rst          = ($urandom_range(0, 99) < 2);
      i_enable       = ($urandom_range(0, 9) < 8);
      i_period       = CNT_W'($urandom_range(0, 6));
      i_activity     = ($urandom_range(0, 9) == 0);
      i_kick_ready   = ($urandom_range(0, 1) == 1);
      i_clear_status = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
